// File: rtl/beacon_sched.sv
// beacon_sched: frame scheduler for the beacon transmitter.
// Each frame is one start slot followed by ID_W ID slots (MSB first). A
// one-cycle tx_stb at the top of a slot keys a 1; a 0 leaves the slot silent.
// Frames repeat on a programmable period, and manual one-shot requests are
// merged with the periodic schedule.
module beacon_sched #(
    parameter int ID_W     = 8,
    parameter int SLOT_LEN = 1536,
    parameter int PER_W    = 24
) (
    input  logic             xtal_in,
    input  logic             rst,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    input  logic [ID_W-1:0]  beacon_id,
    input  logic             manual_req,
    output logic             tx_stb,
    output logic             busy,
    output logic             manual_ack,
    output logic             frame_done,
    output logic [15:0]      frame_cnt
);

    localparam int SLOT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int BIT_W  = $clog2(ID_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SLOT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [SLOT_W-1:0] slot_cnt_reg, slot_cnt_next;
    logic [BIT_W-1:0]  bit_idx_reg, bit_idx_next;
    logic [ID_W:0]     shreg_reg, shreg_next;
    logic [PER_W-1:0]  timer_reg, timer_next;
    logic              timer_run_reg, timer_run_next;
    logic              per_pend_reg, per_pend_next;
    logic              man_pend_reg, man_pend_next;
    logic              enable_d_reg;
    logic              tx_stb_reg, tx_stb_next;
    logic              busy_reg, busy_next;
    logic              manual_ack_reg, manual_ack_next;
    logic              frame_done_reg, frame_done_next;
    logic [15:0]       frame_cnt_reg, frame_cnt_next;

    logic start;
    logic slot_last;
    logic frame_last;
    logic expire;

    // Frame start is evaluated only from IDLE; manual_req is honoured the same cycle.
    assign start      = (state_reg == IDLE) && (per_pend_reg || man_pend_reg || manual_req);
    assign slot_last  = (slot_cnt_reg == SLOT_W'(SLOT_LEN - 1));
    assign frame_last = (bit_idx_reg == BIT_W'(ID_W));
    // Expiring two counts early lets the registered start land exactly on T+period.
    assign expire     = timer_run_reg && (timer_reg <= PER_W'(2));

    // State register.
    always_ff @(posedge xtal_in) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = SLOT;
            SLOT: if (slot_last && frame_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slot datapath and registered-output next values.
    always_comb begin
        slot_cnt_next   = slot_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shreg_next      = shreg_reg;
        tx_stb_next     = 1'b0;
        busy_next       = (state_next == SLOT);
        manual_ack_next = 1'b0;
        frame_done_next = 1'b0;
        frame_cnt_next  = frame_cnt_reg;
        if (start) begin
            slot_cnt_next   = '0;
            bit_idx_next    = '0;
            shreg_next      = {1'b1, beacon_id};
            tx_stb_next     = 1'b1;
            manual_ack_next = man_pend_reg || manual_req;
        end else if (state_reg == SLOT) begin
            slot_cnt_next   = slot_last ? '0 : SLOT_W'(slot_cnt_reg + SLOT_W'(1));
            frame_done_next = frame_last && (slot_cnt_reg == SLOT_W'(SLOT_LEN - 2));
            if (slot_last) begin
                if (frame_last) begin
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                end else begin
                    // The bit after the current MSB becomes the next slot's bit.
                    bit_idx_next = BIT_W'(bit_idx_reg + BIT_W'(1));
                    shreg_next   = shreg_reg << 1;
                    tx_stb_next  = shreg_reg[ID_W-1];
                end
            end
        end
    end

    // Period timer and pending-request flags.
    always_comb begin
        timer_next     = (timer_reg == '0) ? '0 : PER_W'(timer_reg - PER_W'(1));
        timer_run_next = timer_run_reg && !expire;
        if (start) begin
            timer_next     = period;
            timer_run_next = 1'b1;
        end
        per_pend_next = per_pend_reg || (enable && !enable_d_reg) || (expire && enable);
        if (start || !enable) per_pend_next = 1'b0;
        man_pend_next = man_pend_reg || ((state_reg == SLOT) && manual_req);
        if (start) man_pend_next = 1'b0;
    end

    // Datapath and output registers.
    always_ff @(posedge xtal_in) begin
        if (rst) begin
            slot_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shreg_reg      <= '0;
            timer_reg      <= '0;
            timer_run_reg  <= 1'b0;
            per_pend_reg   <= 1'b0;
            man_pend_reg   <= 1'b0;
            enable_d_reg   <= 1'b0;
            tx_stb_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            manual_ack_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            slot_cnt_reg   <= slot_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shreg_reg      <= shreg_next;
            timer_reg      <= timer_next;
            timer_run_reg  <= timer_run_next;
            per_pend_reg   <= per_pend_next;
            man_pend_reg   <= man_pend_next;
            enable_d_reg   <= enable;
            tx_stb_reg     <= tx_stb_next;
            busy_reg       <= busy_next;
            manual_ack_reg <= manual_ack_next;
            frame_done_reg <= frame_done_next;
            frame_cnt_reg  <= frame_cnt_next;
        end
    end

    assign tx_stb     = tx_stb_reg;
    assign busy       = busy_reg;
    assign manual_ack = manual_ack_reg;
    assign frame_done = frame_done_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_beacon_sched.sv
// Directed bench for beacon_sched with ID_W=4, SLOT_LEN=16 (F=80 cycles).
// Expected strobe / ack / done cycles are queued when stimulus is applied and
// consumed by a monitor as the DUT produces them.
module tb_beacon_sched;

    localparam int ID_W     = 4;
    localparam int SLOT_LEN = 16;
    localparam int PER_W    = 24;
    localparam int F        = (1 + ID_W) * SLOT_LEN;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [PER_W-1:0] period;
    logic [ID_W-1:0]  beacon_id;
    logic             manual_req;
    logic             tx_stb;
    logic             busy;
    logic             manual_ack;
    logic             frame_done;
    logic [15:0]      frame_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int exp_stb[$];
    int exp_ack[$];
    int exp_done[$];
    logic stb_prev = 1'b0;

    beacon_sched #(.ID_W(ID_W), .SLOT_LEN(SLOT_LEN), .PER_W(PER_W)) dut (
        .xtal_in   (clk),
        .rst       (rst),
        .enable    (enable),
        .period    (period),
        .beacon_id (beacon_id),
        .manual_req(manual_req),
        .tx_stb    (tx_stb),
        .busy      (busy),
        .manual_ack(manual_ack),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Queue the strobes, done pulse and optional ack of one full frame starting at t.
    task automatic push_frame(input int t, input logic [ID_W-1:0] id, input bit ack);
        exp_stb.push_back(t);
        for (int k = 1; k <= ID_W; k++)
            if (id[ID_W-k]) exp_stb.push_back(t + k * SLOT_LEN);
        exp_done.push_back(t + F - 1);
        if (ack) exp_ack.push_back(t);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_stb_left"},  exp_stb.size(),  0);
        check({tag, "_ack_left"},  exp_ack.size(),  0);
        check({tag, "_done_left"}, exp_done.size(), 0);
    endtask

    // Monitor: each observed pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (tx_stb) begin
            check("stb_not_consecutive", int'(stb_prev), 0);
            if (exp_stb.size() == 0) check("stb_unexpected", cyc, -1);
            else check("stb_cycle", cyc, exp_stb.pop_front());
        end
        stb_prev = tx_stb;
        if (manual_ack) begin
            if (exp_ack.size() == 0) check("ack_unexpected", cyc, -1);
            else check("ack_cycle", cyc, exp_ack.pop_front());
        end
        if (frame_done) begin
            $display("frame_done cycle=%0d frame_cnt=%0d", cyc, frame_cnt);
            if (exp_done.size() == 0) check("done_unexpected", cyc, -1);
            else check("done_cycle", cyc, exp_done.pop_front());
        end
    end

    initial begin
        int t;
        int c;
        int cnt0;
        rst        = 1'b1;
        enable     = 1'b0;
        period     = 24'd200;
        beacon_id  = 4'b1010;
        manual_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_stb",     int'(tx_stb),     0);
        check("rst_busy",       int'(busy),       0);
        check("rst_manual_ack", int'(manual_ack), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_cnt",  int'(frame_cnt),  0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Periodic frames, period 200, ID 1010.
        c = cyc; enable = 1'b1; t = c + 2;
        push_frame(t, 4'b1010, 0);
        push_frame(t + 200, 4'b1010, 0);
        wait_until(t);
        check("p_busy_at_start", int'(busy), 1);
        wait_until(t + F - 1);
        check("p_busy_at_done", int'(busy), 1);
        wait_until(t + F);
        check("p_busy_after", int'(busy), 0);
        check("p_cnt_first", int'(frame_cnt), 1);
        wait_until(t + 285);
        enable = 1'b0;
        wait_until(t + 450);
        check("p_cnt_second", int'(frame_cnt), 2);
        check_drained("periodic");

        // Short period: back-to-back frames 81 cycles apart.
        period = 24'd10; beacon_id = 4'b1111;
        c = cyc; enable = 1'b1; t = c + 2;
        push_frame(t, 4'b1111, 0);
        push_frame(t + 81, 4'b1111, 0);
        push_frame(t + 162, 4'b1111, 0);
        wait_until(t + 170);
        enable = 1'b0;
        wait_until(t + 260);
        check("short_cnt", int'(frame_cnt), 5);
        check("short_busy", int'(busy), 0);
        check_drained("short");

        // Manual request while disabled.
        beacon_id = 4'b0011;
        c = cyc; manual_req = 1'b1; t = c + 1;
        push_frame(t, 4'b0011, 1);
        @(negedge clk); manual_req = 1'b0;
        wait_until(t + 90);
        check("man_cnt", int'(frame_cnt), 6);
        check_drained("manual");

        // Manual mid-frame together with a pending periodic start.
        beacon_id = 4'b1001; period = 24'd10;
        c = cyc; enable = 1'b1; t = c + 2;
        push_frame(t, 4'b1001, 0);
        push_frame(t + 81, 4'b1001, 1);
        wait_until(t + 30);
        manual_req = 1'b1;
        @(negedge clk); manual_req = 1'b0;
        wait_until(t + 90);
        enable = 1'b0;
        wait_until(t + 81 + 100);
        check("mix_cnt", int'(frame_cnt), 8);
        check_drained("mixed");

        // beacon_id change and enable drop during slot 2.
        beacon_id = 4'b1010; period = 24'd200;
        cnt0 = int'(frame_cnt);
        c = cyc; enable = 1'b1; t = c + 2;
        push_frame(t, 4'b1010, 0);
        wait_until(t + 35);
        beacon_id = 4'b0101; enable = 1'b0;
        wait_until(t + 300);
        check("chg_cnt", int'(frame_cnt), cnt0 + 1);
        check_drained("change");

        // Reset during slot 1: frame aborted, no strobe at T+48.
        beacon_id = 4'b1010;
        c = cyc; enable = 1'b1; t = c + 2;
        exp_stb.push_back(t);
        exp_stb.push_back(t + SLOT_LEN);
        wait_until(t + 20);
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("mrst_tx_stb",     int'(tx_stb),     0);
        check("mrst_busy",       int'(busy),       0);
        check("mrst_manual_ack", int'(manual_ack), 0);
        check("mrst_frame_done", int'(frame_done), 0);
        check("mrst_frame_cnt",  int'(frame_cnt),  0);
        rst = 1'b0;
        wait_until(t + 150);
        check("mrst_busy_later", int'(busy), 0);
        check_drained("midrst");

        // frame_cnt wrap from 0xFFFF.
        force dut.frame_cnt_reg = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_reg;
        @(negedge clk);
        check("wrap_preload", int'(frame_cnt), 16'hFFFF);
        c = cyc; manual_req = 1'b1; t = c + 1;
        push_frame(t, 4'b1010, 1);
        @(negedge clk); manual_req = 1'b0;
        wait_until(t + 90);
        check("wrap_cnt", int'(frame_cnt), 0);
        check_drained("wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beacon_sched.md
# beacon_sched

Frame scheduler for the beacon transmitter. It sequences the PLL burst transmitter by issuing one-cycle `tx_stb` strobes, which on-off key a start bit plus a beacon ID, one bit per fixed-length slot. Frames repeat on a programmable period, and a manual one-shot request path is arbitrated against the periodic schedule. It sits between the control/config logic and `tx`, all in the `xtal_in` domain.

## Interface
- `ID_W`, 8: beacon ID width; frame = 1 start slot + `ID_W` ID slots.
- `SLOT_LEN`, 1536: cycles per slot; must exceed the tx burst duration (about 1027 cycles).
- `PER_W`, 24: width of the period input.
- `xtal_in` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: periodic scheduling enable.
- `period` in `PER_W`: frame-start-to-frame-start spacing in cycles; 0 means back-to-back.
- `beacon_id` in `ID_W`: ID sent MSB first.
- `manual_req` in 1: request one frame (level or pulse, sampled each cycle).
- `tx_stb` out 1: one-cycle strobe to `tx`.
- `busy` out 1: high while a frame is in progress.
- `manual_ack` out 1: one-cycle pulse; the frame starting this cycle serves the pending manual request.
- `frame_done` out 1: one-cycle pulse on the last cycle of a frame.
- `frame_cnt` out 16: completed-frame counter.

## Operation
- **States:**
  - IDLE: no frame in progress.
  - SLOT: a frame is being sent; a slot counter runs 0..`SLOT_LEN`-1 and a bit index runs 0..`ID_W`.
- **Frame start:**
  - Condition: in IDLE with `per_pend` or `man_pend`, or with `manual_req` high.
  - On start: snapshot `beacon_id` together with the start bit into a shift register, enter SLOT, and reset both counters to 0.
- **Keying:**
  - At slot count 0, `tx_stb` = current bit.
  - A 1 strobes `tx`; a 0 is a silent slot of the same length.
  - The start bit is always 1.
- **Slot advance:**
  - At slot count `SLOT_LEN`-1, advance the bit index.
  - At bit index `ID_W`: pulse `frame_done`, increment `frame_cnt` (wraps 0xFFFF to 0), and return to IDLE.
- **man_pend:**
  - Set by `manual_req` while in SLOT.
  - Cleared at the frame start that serves it; `manual_ack` pulses on that cycle.
  - Does not depend on `enable`.
- **per_pend:**
  - Set by the `enable` 0→1 edge, so the first frame goes out immediately.
  - Also set when the period timer expires while `enable`=1.
  - Cleared at frame start, or whenever `enable`=0.
- **Period timer:**
  - Loaded with `period` at each frame start (cycle T) and decrements each cycle.
  - Expires so that the next periodic start is at T+`period`, clamped to no earlier than T+F+1, where F = (1+`ID_W`)·`SLOT_LEN`.
- **Simultaneous periodic and manual:** one frame serves both; `manual_ack` pulses and `frame_cnt` increments by 1.
- **`enable` dropped mid-frame:** the current frame completes; no further periodic frames start.
- **`beacon_id` changed mid-frame:** no effect until the next frame start.
- **`period` changed:** takes effect at the next frame start.
- **`rst` mid-frame:** next cycle is IDLE, all outputs 0, both pending flags cleared, `frame_cnt`=0. A `tx` burst already launched is not recalled.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Start latency: start condition true at cycle c, so `busy`, `tx_stb` (start bit) and any `manual_ack` all assert at c+1.
- Bit k strobe occurs at T + k·`SLOT_LEN`, where T is the start-bit strobe cycle.
- `frame_done` is asserted at T+F-1, and `busy` falls at T+F.
- Minimum start-to-start spacing is F+1 cycles.
- `tx_stb` is never high on two consecutive cycles.

## Test plan
Bench uses `ID_W`=4 and `SLOT_LEN`=16, so F=80.
- **Periodic frame:** `rst` then `enable`=1, `beacon_id`=4'b1010, `period`=200 → strobes at T, T+16, T+48; `frame_done` at T+79; next start at T+200; `frame_cnt`=1 after the first frame.
- **Short period:** `period`=10, `beacon_id`=4'b1111 → frames back-to-back with starts 81 cycles apart, and 5 strobes per frame at 16-cycle spacing.
- **Manual while disabled:** `enable`=0, `manual_req` pulse at cycle c → `tx_stb` and `manual_ack` at c+1, one frame, `frame_cnt`=1.
- **Manual mid-frame, coinciding with periodic:** `manual_req` pulse mid-frame while the periodic timer also expires → a single frame at T+81 with `manual_ack`, and `frame_cnt` increments by 1.
- **Mid-frame changes:** `beacon_id` changed from 4'b1010 to 4'b0101 and `enable` dropped during slot 2 → strobes remain at T, T+16, T+48; frame completes; no further starts.
- **Reset mid-frame and counter wrap:** `rst` at T+20 → outputs 0 at T+21 and no strobe at T+48. Separately, force `frame_cnt`=0xFFFF and run one frame → `frame_cnt` reads 0.
